// File: rtl/gearbox_align_ctl.sv
// gearbox_align_ctl: word-alignment controller for the 32-to-N receive gearbox.
// Watches the sync header in the MSBs of each gearbox output word, issues
// bitslips until headers are consistently valid, then holds lock while
// monitoring header errors per window.
// Optional statistics counters are enabled by defining GEARBOX_ALIGN_STATS_EN.
module gearbox_align_ctl #(
   parameter int WIDTH      = 40,
   parameter int HDR_BITS   = 2,
   parameter int LOCK_COUNT = 64,
   parameter int WINDOW     = 1024,
   parameter int UNLOCK_BAD = 16,
   parameter int SLIP_BLANK = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [WIDTH-1:0]         data_in,
   input  logic                     valid_in,
   input  logic                     gb_in_valid,
   output logic                     bitslip,
   output logic                     locked,
   output logic [$clog2(WIDTH)-1:0] slip_offset,
   output logic                     slip_wrap
`ifdef GEARBOX_ALIGN_STATS_EN
   ,
   input  logic                     stats_clr,
   output logic [15:0]              lock_loss_count,
   output logic [15:0]              slip_total
`endif
);

   localparam int OW = $clog2(WIDTH);
   localparam int GW = $clog2(LOCK_COUNT) + 1;
   localparam int WW = $clog2(WINDOW) + 1;
   localparam int BW = $clog2(UNLOCK_BAD) + 1;
   localparam int KW = $clog2(SLIP_BLANK + 1) + 1;

   localparam logic [OW-1:0] OFF_MAX    = OW'(WIDTH - 1);
   localparam logic [GW-1:0] LOCK_M1    = GW'(LOCK_COUNT - 1);
   localparam logic [WW-1:0] WIN_M1     = WW'(WINDOW - 1);
   localparam logic [BW-1:0] UNLOCK_M1  = BW'(UNLOCK_BAD - 1);
   localparam logic [KW-1:0] BLANK_INIT = KW'(SLIP_BLANK);

   typedef enum logic [1:0] {HUNT, SLIP, BLANK, LOCKED} state_t;

   state_t        state, state_nxt;
   logic [GW-1:0] good_cnt, good_nxt;
   logic [WW-1:0] win_cnt, win_nxt;
   logic [BW-1:0] bad_cnt, bad_nxt;
   logic [KW-1:0] blank_cnt, blank_nxt;
   logic [OW-1:0] off_nxt;
   logic          locked_nxt, wrap_nxt;

   logic [HDR_BITS-1:0] hdr;
   logic                hdr_ok;
   logic                unused_lsb;

   // Sync header is valid only when it contains both a 0 and a 1.
   assign hdr        = data_in[WIDTH-1 -: HDR_BITS];
   assign hdr_ok     = (hdr != '0) && (hdr != '1);
   assign unused_lsb = ^data_in[WIDTH-HDR_BITS-1:0];

   // The slip request is exactly the SLIP state, so it is a clean flop decode.
   assign bitslip = (state == SLIP);

   // Next-state and counter update logic.
   always_comb begin
      state_nxt  = state;
      good_nxt   = good_cnt;
      win_nxt    = win_cnt;
      bad_nxt    = bad_cnt;
      blank_nxt  = blank_cnt;
      off_nxt    = slip_offset;
      locked_nxt = locked;
      wrap_nxt   = 1'b0;
      case (state)
         HUNT: begin
            if (!enable) begin
               good_nxt = '0;
            end else if (valid_in) begin
               if (hdr_ok) begin
                  if (good_cnt == LOCK_M1) begin
                     state_nxt  = LOCKED;
                     locked_nxt = 1'b1;
                     good_nxt   = '0;
                     win_nxt    = '0;
                     bad_nxt    = '0;
                  end else begin
                     good_nxt = good_cnt + GW'(1);
                  end
               end else begin
                  good_nxt  = '0;
                  state_nxt = SLIP;
               end
            end
         end
         SLIP: begin
            // Once raised, the request is held until the gearbox takes it,
            // even if enable drops, so a slip is never half-issued.
            if (gb_in_valid) begin
               wrap_nxt = (slip_offset == OFF_MAX);
               off_nxt  = (slip_offset == OFF_MAX) ? '0 : slip_offset + OW'(1);
               good_nxt = '0;
               if (!enable || SLIP_BLANK == 0) begin
                  state_nxt = HUNT;
               end else begin
                  state_nxt = BLANK;
                  blank_nxt = BLANK_INIT;
               end
            end
         end
         BLANK: begin
            if (!enable) begin
               state_nxt = HUNT;
               blank_nxt = '0;
            end else if (valid_in) begin
               if (blank_cnt <= KW'(1)) begin
                  state_nxt = HUNT;
                  blank_nxt = '0;
                  good_nxt  = '0;
               end else begin
                  blank_nxt = blank_cnt - KW'(1);
               end
            end
         end
         LOCKED: begin
            if (!enable) begin
               state_nxt  = HUNT;
               locked_nxt = 1'b0;
               win_nxt    = '0;
               bad_nxt    = '0;
            end else if (valid_in) begin
               if (!hdr_ok && bad_cnt == UNLOCK_M1) begin
                  state_nxt  = HUNT;
                  locked_nxt = 1'b0;
                  win_nxt    = '0;
                  bad_nxt    = '0;
                  good_nxt   = '0;
               end else if (win_cnt == WIN_M1) begin
                  win_nxt = '0;
                  bad_nxt = '0;
               end else begin
                  win_nxt = win_cnt + WW'(1);
                  if (!hdr_ok) bad_nxt = bad_cnt + BW'(1);
               end
            end
         end
         default: begin
            state_nxt  = HUNT;
            locked_nxt = 1'b0;
         end
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HUNT;
         good_cnt    <= '0;
         win_cnt     <= '0;
         bad_cnt     <= '0;
         blank_cnt   <= '0;
         slip_offset <= '0;
         locked      <= 1'b0;
         slip_wrap   <= 1'b0;
      end else begin
         state       <= state_nxt;
         good_cnt    <= good_nxt;
         win_cnt     <= win_nxt;
         bad_cnt     <= bad_nxt;
         blank_cnt   <= blank_nxt;
         slip_offset <= off_nxt;
         locked      <= locked_nxt;
         slip_wrap   <= wrap_nxt;
      end
   end

`ifdef GEARBOX_ALIGN_STATS_EN
   logic lock_loss, slip_acc;

   assign lock_loss = (state == LOCKED) && (state_nxt == HUNT);
   assign slip_acc  = (state == SLIP) && gb_in_valid;

   // Saturating event counters; a clear request beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         lock_loss_count <= '0;
         slip_total      <= '0;
      end else begin
         if (lock_loss && lock_loss_count != 16'hFFFF)
            lock_loss_count <= lock_loss_count + 16'd1;
         if (slip_acc && slip_total != 16'hFFFF)
            slip_total <= slip_total + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gearbox_align_ctl.sv
// Directed testbench for gearbox_align_ctl (WIDTH=40 defaults).
module tb_gearbox_align_ctl;

   localparam logic [1:0] GOOD = 2'b01;
   localparam logic [1:0] BAD0 = 2'b00;
   localparam logic [1:0] BAD1 = 2'b11;

   logic        clk = 1'b0;
   logic        rst, enable, valid_in, gb_in_valid;
   logic [39:0] data_in;
   logic        bitslip, locked, slip_wrap;
   logic [5:0]  slip_offset;
`ifdef GEARBOX_ALIGN_STATS_EN
   logic        stats_clr;
   logic [15:0] lock_loss_count, slip_total;
`endif

   int pass_cnt = 0;
   int tot_cnt  = 0;

   gearbox_align_ctl dut (
      .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
      .valid_in(valid_in), .gb_in_valid(gb_in_valid), .bitslip(bitslip),
      .locked(locked), .slip_offset(slip_offset), .slip_wrap(slip_wrap)
`ifdef GEARBOX_ALIGN_STATS_EN
      , .stats_clr(stats_clr), .lock_loss_count(lock_loss_count),
      .slip_total(slip_total)
`endif
   );

   always #5 clk = ~clk;

   // Apply one word at a negedge, then advance to the next negedge so the
   // outputs seen afterwards reflect the posedge that consumed it.
   task automatic step(input logic [1:0] hdr, input logic v, input logic gbv);
      data_in     = {hdr, 6'h0, 32'($urandom())};
      valid_in    = v;
      gb_in_valid = gbv;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b1; valid_in = 1'b0; gb_in_valid = 1'b1;
      data_in = '0;
`ifdef GEARBOX_ALIGN_STATS_EN
      stats_clr = 1'b0;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic lock_up();
      for (int i = 0; i < 64; i++) step(GOOD, 1'b1, 1'b1);
   endtask

   task automatic test_reset();
      do_reset();
      tot_cnt++;
      if ({bitslip, locked, slip_offset, slip_wrap} !== 9'd0)
         $display("FAIL reset_outputs got bs=%b lk=%b off=%0d wr=%b want all 0",
                  bitslip, locked, slip_offset, slip_wrap);
      else pass_cnt++;
   endtask

   task automatic test_aligned();
      int highs = 0;
      do_reset();
      for (int i = 1; i <= 64; i++) begin
         if (i % 8 == 0) begin
            step(BAD0, 1'b0, 1'b1);               // not valid: must be ignored
            if (bitslip) highs++;
         end
         step(GOOD, 1'b1, 1'b1);
         if (bitslip) highs++;
         if (i == 63) begin
            tot_cnt++;
            if (locked !== 1'b0) $display("FAIL aligned_early got locked=%b want 0", locked);
            else pass_cnt++;
         end
      end
      tot_cnt++;
      if (locked !== 1'b1) $display("FAIL aligned_lock got locked=%b want 1", locked);
      else pass_cnt++;
      tot_cnt++;
      if (highs != 0) $display("FAIL aligned_noslip got %0d bitslip cycles want 0", highs);
      else pass_cnt++;
   endtask

   task automatic test_misaligned();
      int blank_highs = 0;
      do_reset();
      for (int r = 0; r < 3; r++) begin
         step(BAD0, 1'b1, 1'b1);
         tot_cnt++;
         if (bitslip !== 1'b1) $display("FAIL mis_slip_rise r=%0d got bs=%b want 1", r, bitslip);
         else pass_cnt++;
         step(BAD1, 1'b0, 1'b1);
         tot_cnt++;
         if (bitslip !== 1'b0 || slip_offset !== 6'(r + 1))
            $display("FAIL mis_slip_accept r=%0d got bs=%b off=%0d want bs=0 off=%0d",
                     r, bitslip, slip_offset, r + 1);
         else pass_cnt++;
         for (int b = 0; b < 4; b++) begin
            step(BAD0, 1'b1, 1'b1);
            if (bitslip) blank_highs++;
         end
      end
      tot_cnt++;
      if (blank_highs != 0) $display("FAIL mis_blank got %0d slip cycles want 0", blank_highs);
      else pass_cnt++;
      for (int i = 1; i <= 64; i++) begin
         step(GOOD, 1'b1, 1'b1);
         if (i == 63) begin
            tot_cnt++;
            if (locked !== 1'b0) $display("FAIL mis_early got locked=%b want 0", locked);
            else pass_cnt++;
         end
      end
      tot_cnt++;
      if (locked !== 1'b1 || slip_offset !== 6'd3)
         $display("FAIL mis_lock got locked=%b off=%0d want 1 and 3", locked, slip_offset);
      else pass_cnt++;
`ifdef GEARBOX_ALIGN_STATS_EN
      tot_cnt++;
      if (slip_total !== 16'd3) $display("FAIL stats_slip_total got %0d want 3", slip_total);
      else pass_cnt++;
`endif
   endtask

   task automatic test_held_slip();
      int highs = 0;
      do_reset();
      step(BAD1, 1'b1, 1'b0);
      if (bitslip) highs++;
      for (int i = 0; i < 5; i++) begin
         step(GOOD, 1'b0, 1'b0);
         if (bitslip) highs++;
      end
      step(GOOD, 1'b0, 1'b1);
      if (bitslip) highs++;
      tot_cnt++;
      if (highs != 6) $display("FAIL held_width got %0d cycles want 6", highs);
      else pass_cnt++;
      tot_cnt++;
      if (slip_offset !== 6'd1) $display("FAIL held_offset got %0d want 1", slip_offset);
      else pass_cnt++;
   endtask

   task automatic test_unlock();
      do_reset();
      lock_up();
      for (int i = 0; i < 15; i++) step(BAD0, 1'b1, 1'b1);
      for (int i = 0; i < 1009; i++) step(GOOD, 1'b1, 1'b1);
      tot_cnt++;
      if (locked !== 1'b1) $display("FAIL unlock_15bad got locked=%b want 1", locked);
      else pass_cnt++;
      for (int i = 0; i < 15; i++) step(BAD1, 1'b1, 1'b1);
      tot_cnt++;
      if (locked !== 1'b1) $display("FAIL unlock_rollover got locked=%b want 1", locked);
      else pass_cnt++;
      step(BAD0, 1'b1, 1'b1);
      tot_cnt++;
      if (locked !== 1'b0 || bitslip !== 1'b0)
         $display("FAIL unlock_16th got locked=%b bs=%b want 0 0", locked, bitslip);
      else pass_cnt++;
`ifdef GEARBOX_ALIGN_STATS_EN
      tot_cnt++;
      if (lock_loss_count !== 16'd1) $display("FAIL stats_lock_loss got %0d want 1", lock_loss_count);
      else pass_cnt++;
      stats_clr = 1'b1;
      step(GOOD, 1'b0, 1'b1);
      stats_clr = 1'b0;
      tot_cnt++;
      if (lock_loss_count !== 16'd0) $display("FAIL stats_clr got %0d want 0", lock_loss_count);
      else pass_cnt++;
`endif
      // Back in HUNT: the next bad header must slip.
      step(BAD0, 1'b1, 1'b1);
      tot_cnt++;
      if (bitslip !== 1'b1) $display("FAIL unlock_hunt got bs=%b want 1", bitslip);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      int wraps = 0;
      int off_err = 0;
      do_reset();
      for (int s = 1; s <= 40; s++) begin
         step(BAD0, 1'b1, 1'b1);
         if (slip_wrap) wraps++;
         step(BAD0, 1'b0, 1'b1);
         if (slip_wrap) wraps++;
         if (slip_offset !== 6'(s % 40)) off_err++;
         if (s == 40) begin
            tot_cnt++;
            if (slip_wrap !== 1'b1 || slip_offset !== 6'd0)
               $display("FAIL wrap_pulse got wr=%b off=%0d want 1 0", slip_wrap, slip_offset);
            else pass_cnt++;
         end
         for (int b = 0; b < 4; b++) begin
            step(GOOD, 1'b1, 1'b1);
            if (slip_wrap) wraps++;
         end
      end
      tot_cnt++;
      if (wraps != 1) $display("FAIL wrap_count got %0d pulses want 1", wraps);
      else pass_cnt++;
      tot_cnt++;
      if (off_err != 0) $display("FAIL wrap_offsets got %0d wrong offsets want 0", off_err);
      else pass_cnt++;
   endtask

   task automatic test_disable_reset();
      int highs = 0;
      do_reset();
      step(BAD0, 1'b1, 1'b0);
      enable = 1'b0;
      step(BAD0, 1'b1, 1'b0);
      step(BAD0, 1'b1, 1'b0);
      tot_cnt++;
      if (bitslip !== 1'b1 || locked !== 1'b0)
         $display("FAIL dis_hold got bs=%b lk=%b want 1 0", bitslip, locked);
      else pass_cnt++;
      step(BAD0, 1'b1, 1'b1);
      tot_cnt++;
      if (bitslip !== 1'b0 || slip_offset !== 6'd1)
         $display("FAIL dis_accept got bs=%b off=%0d want 0 1", bitslip, slip_offset);
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         step(BAD1, 1'b1, 1'b1);
         if (bitslip) highs++;
      end
      tot_cnt++;
      if (highs != 0) $display("FAIL dis_noslip got %0d slip cycles want 0", highs);
      else pass_cnt++;
      // Partial good run, then a disable cycle must clear the good count.
      enable = 1'b1;
      for (int i = 0; i < 30; i++) step(GOOD, 1'b1, 1'b1);
      enable = 1'b0;
      step(GOOD, 1'b1, 1'b1);
      enable = 1'b1;
      for (int i = 0; i < 63; i++) step(GOOD, 1'b1, 1'b1);
      tot_cnt++;
      if (locked !== 1'b0) $display("FAIL dis_cnt_clear got locked=%b want 0", locked);
      else pass_cnt++;
      step(GOOD, 1'b1, 1'b1);
      tot_cnt++;
      if (locked !== 1'b1) $display("FAIL dis_relock got locked=%b want 1", locked);
      else pass_cnt++;
      enable = 1'b0;
      step(GOOD, 1'b1, 1'b1);
      tot_cnt++;
      if (locked !== 1'b0) $display("FAIL dis_unlock got locked=%b want 0", locked);
      else pass_cnt++;
      // Reset while a slip is pending drops the request on the next edge.
      enable = 1'b1;
      step(BAD0, 1'b1, 1'b0);
      tot_cnt++;
      if (bitslip !== 1'b1) $display("FAIL rst_pre got bs=%b want 1", bitslip);
      else pass_cnt++;
      rst = 1'b1;
      step(GOOD, 1'b0, 1'b0);
      rst = 1'b0;
      tot_cnt++;
      if (bitslip !== 1'b0 || slip_offset !== 6'd0)
         $display("FAIL rst_midslip got bs=%b off=%0d want 0 0", bitslip, slip_offset);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_misaligned();
      test_held_slip();
      test_unlock();
      test_wrap();
      test_disable_reset();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
